// File: rtl/music_seq_pkg.sv
// Shared definitions for the music player playback/write sequencer.
//   state_t      : sequencer FSM states
//   NOTE_W_DEF   : default tone index width (index 0 = rest)
//   DUR_W_DEF    : default duration field width (duration 0 = end of song)
//   DUR_LSB      : song entry is {note, dur}; dur sits in the LSBs and the
//                  note field starts at DUR_LSB + DUR_W
//   END_DUR      : duration value that marks end of song
//   REST_NOTE    : tone index for silence
package music_seq_pkg;

    localparam int unsigned NOTE_W_DEF = 4;
    localparam int unsigned DUR_W_DEF  = 4;

    localparam int unsigned DUR_LSB    = 0;

    localparam int unsigned END_DUR    = 0;
    localparam int unsigned REST_NOTE  = 0;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_ADDR,
        RD_CAPTURE,
        PLAY_NOTE
    } state_t;

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter timing one note.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (has priority over en)
//   en        : count down by one while value is non-zero
//   load_val  : initial count (cycles the note lasts)
//   value     : current count
//   last      : high when value == 1, i.e. the final cycle of the note
module note_timer #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign last = (value == W'(1));

endmodule

// File: rtl/music_seq_ctrl.sv
// Shares the single port of the latch-based song memory between host note
// writes (setup / pulse / hold around the latch enable) and autonomous
// playback, which walks the song and sounds one note at a time.
//   clk, rst    : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data/wr_ready : host write request ({note, dur})
//   play, stop  : start playback at address 0 / abort playback
//   mem_addr/mem_wdata/mem_wen/mem_rdata : song memory port
//   note_out/note_valid : tone index to the tone generator
//   busy        : not idle
//   done        : one-cycle pulse at end of song (marker or wrap)
module music_seq_ctrl
    import music_seq_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NOTE_W   = NOTE_W_DEF,
    parameter int unsigned DUR_W    = DUR_W_DEF,
    parameter int unsigned TICK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [NOTE_W+DUR_W-1:0] wr_data,
    output logic                    wr_ready,
    input  logic                    play,
    input  logic                    stop,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [NOTE_W+DUR_W-1:0] mem_wdata,
    output logic                    mem_wen,
    input  logic [NOTE_W+DUR_W-1:0] mem_rdata,
    output logic [NOTE_W-1:0]       note_out,
    output logic                    note_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned EW = NOTE_W + DUR_W;
    localparam int unsigned TW = DUR_W + $clog2(TICK_DIV + 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic                pend, pend_nxt;
    logic [NOTE_W-1:0]   note_q, note_nxt;
    logic [DUR_W-1:0]    dur_q, dur_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [EW-1:0]       mem_wdata_nxt;
    logic                mem_wen_nxt, done_nxt, note_valid_nxt;
    logic [NOTE_W-1:0]   note_out_nxt;

    logic                tmr_load, tmr_en, tmr_last;
    logic [TW-1:0]       tmr_load_val, tmr_value;

    logic [NOTE_W-1:0]   rd_note;
    logic [DUR_W-1:0]    rd_dur;

    assign rd_dur  = mem_rdata[DUR_LSB +: DUR_W];
    assign rd_note = mem_rdata[DUR_LSB + DUR_W +: NOTE_W];

    assign tmr_load_val = TW'(dur_q) * TW'(TICK_DIV);

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    note_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_load_val),
        .value    (tmr_value),
        .last     (tmr_last)
    );

    // Outputs are registered, so each *_nxt describes the cycle after the
    // edge. mem_addr is already valid throughout RD_ADDR, so the entry is
    // taken from mem_rdata at the end of RD_ADDR and held in note_q/dur_q
    // during RD_CAPTURE; this lets done be high in the RD_CAPTURE cycle.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        pend_nxt      = pend;
        note_nxt      = note_q;
        dur_nxt       = dur_q;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        done_nxt      = 1'b0;
        tmr_load      = 1'b0;
        tmr_en        = 1'b0;

        unique case (state)
            IDLE: begin
                if (wr_en) begin
                    mem_addr_nxt  = wr_addr;
                    mem_wdata_nxt = wr_data;
                    pend_nxt      = play;
                    state_nxt     = WR_SETUP;
                end else if (play) begin
                    ptr_nxt      = '0;
                    mem_addr_nxt = '0;
                    state_nxt    = RD_ADDR;
                end
            end
            WR_SETUP: begin
                if (stop) pend_nxt = 1'b0;
                state_nxt = WR_PULSE;
            end
            WR_PULSE: begin
                if (stop) pend_nxt = 1'b0;
                state_nxt = WR_HOLD;
            end
            WR_HOLD: begin
                pend_nxt = 1'b0;
                if (pend && !stop) begin
                    ptr_nxt      = '0;
                    mem_addr_nxt = '0;
                    state_nxt    = RD_ADDR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RD_ADDR: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    note_nxt  = rd_note;
                    dur_nxt   = rd_dur;
                    done_nxt  = (rd_dur == DUR_W'(END_DUR));
                    state_nxt = RD_CAPTURE;
                end
            end
            RD_CAPTURE: begin
                if (stop || dur_q == DUR_W'(END_DUR)) begin
                    state_nxt = IDLE;
                end else begin
                    tmr_load  = 1'b1;
                    // single-cycle note on the final address: it is also the wrap cycle
                    done_nxt  = (tmr_load_val == TW'(1)) && (ptr == '1);
                    state_nxt = PLAY_NOTE;
                end
            end
            PLAY_NOTE: begin
                tmr_en = 1'b1;
                if (stop) begin
                    state_nxt = IDLE;
                end else if (tmr_last) begin
                    ptr_nxt = ptr + 1'b1;
                    if (ptr == '1) begin
                        state_nxt = IDLE;
                    end else begin
                        mem_addr_nxt = ptr + 1'b1;
                        state_nxt    = RD_ADDR;
                    end
                end else begin
                    // next cycle is the last one of the final entry's note
                    done_nxt = (tmr_value == TW'(2)) && (ptr == '1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        mem_wen_nxt    = (state_nxt == WR_PULSE);
        note_valid_nxt = (state_nxt == PLAY_NOTE);
        note_out_nxt   = note_valid_nxt ? note_q : NOTE_W'(REST_NOTE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            pend       <= 1'b0;
            note_q     <= '0;
            dur_q      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wen    <= 1'b0;
            done       <= 1'b0;
            note_valid <= 1'b0;
            note_out   <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            pend       <= pend_nxt;
            note_q     <= note_nxt;
            dur_q      <= dur_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_wen    <= mem_wen_nxt;
            done       <= done_nxt;
            note_valid <= note_valid_nxt;
            note_out   <= note_out_nxt;
        end
    end

endmodule

// File: tb/tb_music_seq_ctrl.sv
module tb_music_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       play;
    logic       stop;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wen;
    logic [7:0] mem_rdata;
    logic [3:0] note_out;
    logic       note_valid;
    logic       busy;
    logic       done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    music_seq_ctrl #(
        .ADDR_W   (5),
        .NOTE_W   (4),
        .DUR_W    (4),
        .TICK_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .play       (play),
        .stop       (stop),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_rdata  (mem_rdata),
        .note_out   (note_out),
        .note_valid (note_valid),
        .busy       (busy),
        .done       (done)
    );

    // song memory model: written while the latch enable is high
    logic [7:0] song [32];
    always @(posedge clk) if (mem_wen) song[mem_addr] <= mem_wdata;
    assign mem_rdata = song[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard of expected notes: tone, cycles valid, gap before (0 = unchecked)
    typedef struct {
        logic [3:0]  note;
        int unsigned len;
        int unsigned gap;
    } ev_t;
    ev_t exp_q[$];

    function automatic void push_note(input logic [3:0] n, input int unsigned len, input int unsigned gap);
        ev_t e;
        e.note = n;
        e.len  = len;
        e.gap  = gap;
        exp_q.push_back(e);
    endfunction

    bit          in_run = 0;
    int unsigned run_len = 0;
    int unsigned gap_len = 0;
    logic [3:0]  run_note = '0;
    ev_t         mon_e;

    always @(negedge clk) begin
        if (rst) begin
            in_run  = 0;
            gap_len = 0;
        end else if (note_valid) begin
            if (!in_run) begin
                in_run   = 1;
                run_len  = 1;
                run_note = note_out;
                if (exp_q.size() > 0 && exp_q[0].gap != 0)
                    check("note_gap", gap_len, exp_q[0].gap);
            end else begin
                run_len++;
            end
        end else begin
            if (in_run) begin
                in_run = 0;
                if (exp_q.size() == 0) begin
                    check("extra_note", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("note_val", run_note, mon_e.note);
                    check("note_len", run_len, mon_e.len);
                end
                gap_len = 0;
            end
            gap_len++;
        end
    end

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 0;
        repeat (3) tick();
    endtask

    task automatic wait_done(input int unsigned limit, output int unsigned n, output bit seen);
        n    = 0;
        seen = 0;
        while (!seen && n < limit) begin
            tick();
            n++;
            if (done) seen = 1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_ready"}, wr_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_nvalid"}, note_valid, 0);
        check({tag, "_note"}, note_out, 0);
        check({tag, "_wen"}, mem_wen, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
    endtask

    int unsigned n;
    bit          seen;
    int unsigned done_seen_cnt;

    initial begin
        rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; play = 0; stop = 0;
        repeat (2) tick();
        check_idle_outputs("reset");
        rst = 0;
        tick();

        // single write {note 5, dur 2} to addr 3
        wr_en = 1; wr_addr = 5'd3; wr_data = 8'h52;
        tick();                                  // t+1
        wr_en = 0;
        check("wr_t1_wen", mem_wen, 0);
        check("wr_t1_addr", mem_addr, 3);
        check("wr_t1_data", mem_wdata, 8'h52);
        check("wr_t1_ready", wr_ready, 0);
        tick();                                  // t+2
        check("wr_t2_wen", mem_wen, 1);
        check("wr_t2_addr", mem_addr, 3);
        check("wr_t2_data", mem_wdata, 8'h52);
        tick();                                  // t+3
        check("wr_t3_wen", mem_wen, 0);
        check("wr_t3_addr", mem_addr, 3);
        check("wr_t3_data", mem_wdata, 8'h52);
        check("wr_t3_ready", wr_ready, 0);
        tick();                                  // t+4
        check("wr_t4_ready", wr_ready, 1);
        check("wr_mem", song[3], 8'h52);

        // short song {0x31, 0x72, end}
        host_write(5'd0, 8'h31);
        host_write(5'd1, 8'h72);
        host_write(5'd2, 8'h00);
        push_note(4'd3, 4, 0);
        push_note(4'd7, 8, 2);
        play = 1;
        tick();                                  // t+1
        play = 0;
        check("play_busy", busy, 1);
        check("play_t1_nv", note_valid, 0);
        tick();
        check("play_t2_nv", note_valid, 0);
        tick();                                  // t+3
        check("play_t3_nv", note_valid, 1);
        check("play_t3_note", note_out, 3);
        wait_done(40, n, seen);
        check("song_done_seen", seen, 1);
        check("song_done_cyc", n, 15);           // done at t+18
        check("song_done_nv", note_valid, 0);
        tick();
        check("song_after_busy", busy, 0);
        check("song_after_done", done, 0);
        repeat (3) tick();
        check("song_sb_empty", exp_q.size(), 0);

        // 32 single-unit notes: wrap ends the song
        for (int unsigned i = 0; i < 32; i++) begin
            host_write(5'(i), {4'(i), 4'h1});
            push_note(4'(i), 4, (i == 0) ? 0 : 2);
        end
        play = 1;
        tick();
        play = 0;
        tick();
        tick();                                  // t+3
        check("wrap_t3_nv", note_valid, 1);
        wait_done(250, n, seen);
        check("wrap_done_seen", seen, 1);
        check("wrap_done_cyc", n, 189);          // done at t+192
        check("wrap_done_nv", note_valid, 1);
        check("wrap_done_note", note_out, 4'd15);
        tick();
        check("wrap_after_busy", busy, 0);
        check("wrap_after_nv", note_valid, 0);
        repeat (8) tick();
        check("wrap_no_reread", busy, 0);
        check("wrap_sb_empty", exp_q.size(), 0);

        // stop on the 2nd PLAY_NOTE cycle
        host_write(5'd0, 8'h52);
        push_note(4'd5, 2, 0);
        done_seen_cnt = 0;
        play = 1;
        tick();
        play = 0;
        tick();
        tick();                                  // t+3
        check("stop_t3_nv", note_valid, 1);
        tick();                                  // t+4
        stop = 1;
        tick();                                  // t+5
        stop = 0;
        check("stop_nv", note_valid, 0);
        check("stop_busy", busy, 0);
        check("stop_note", note_out, 0);
        for (int unsigned i = 0; i < 20; i++) begin
            if (done) done_seen_cnt++;
            tick();
        end
        check("stop_no_done", done_seen_cnt, 0);
        check("stop_sb_empty", exp_q.size(), 0);

        // write and play together: write first, then play from addr 0
        host_write(5'd0, 8'h13);
        host_write(5'd2, 8'h00);
        push_note(4'd1, 12, 0);
        push_note(4'd2, 4, 2);
        wr_en = 1; wr_addr = 5'd1; wr_data = 8'h21; play = 1;
        tick();                                  // t+1
        wr_en = 0; play = 0;
        check("both_t1_wen", mem_wen, 0);
        tick();                                  // t+2
        check("both_t2_wen", mem_wen, 1);
        check("both_t2_addr", mem_addr, 1);
        tick();                                  // t+3
        check("both_t3_wen", mem_wen, 0);
        tick();                                  // t+4: RD_ADDR
        check("both_t4_busy", busy, 1);
        check("both_t4_ready", wr_ready, 0);
        check("both_t4_addr", mem_addr, 0);
        check("both_t4_nv", note_valid, 0);
        wait_done(60, n, seen);
        check("both_done_seen", seen, 1);
        check("both_done_cyc", n, 21);           // done at t+25
        check("both_mem", song[1], 8'h21);
        repeat (3) tick();
        check("both_sb_empty", exp_q.size(), 0);

        // reset during WR_PULSE
        wr_en = 1; wr_addr = 5'd9; wr_data = 8'hA5;
        tick();                                  // t+1
        wr_en = 0;
        tick();                                  // t+2: WR_PULSE
        check("rstw_t2_wen", mem_wen, 1);
        rst = 1;
        tick();                                  // t+3
        rst = 0;
        check_idle_outputs("rstw");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/music_seq_ctrl.md
# music_seq_ctrl

Playback and write sequencer for the music player's latch-based song memory, an array of gate-level D-latch words. It shares the single memory port between host note writes and autonomous playback. Writes use a setup/pulse/hold sequence so each latch enable sees stable address and data. Playback walks the song and presents one note at a time, with its duration, to the tone generator.

## Interface
- ADDR_W, 5, song memory address width (32 entries)
- NOTE_W, 4, tone index width; index 0 = rest
- DUR_W, 4, duration field width; duration 0 = end-of-song marker
- TICK_DIV, 4, clock cycles per duration unit (≥1)
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  host write request; accepted only when wr_ready=1
- wr_addr  in  ADDR_W  host write address
- wr_data  in  NOTE_W+DUR_W  entry {note, dur}; note in the MSBs
- wr_ready  out  1  high only in IDLE
- play  in  1  one-cycle start pulse; playback starts at address 0
- stop  in  1  abort playback
- mem_addr  out  ADDR_W  song memory address
- mem_wdata  out  NOTE_W+DUR_W  song memory write data
- mem_wen  out  1  latch enable for the addressed word
- mem_rdata  in  NOTE_W+DUR_W  song memory read data (combinational mux of latch outputs)
- note_out  out  NOTE_W  current tone index
- note_valid  out  1  high while a note is being sounded
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of song

## Operation
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ADDR, RD_CAPTURE, PLAY_NOTE.
- IDLE, wr_en=1: register wr_addr and wr_data; go to WR_SETUP.
- IDLE, play=1 and wr_en=0: clear the address pointer; go to RD_ADDR.
- IDLE, wr_en=1 and play=1 together: the write wins and play_pending is set. After WR_HOLD, go directly to RD_ADDR at address 0.
- WR_SETUP: drive mem_addr and mem_wdata with mem_wen=0.
- WR_PULSE: same address and data with mem_wen=1.
- WR_HOLD: same address and data with mem_wen=0, then go to IDLE (or to RD_ADDR if play_pending).
- mem_addr and mem_wdata are stable for all three write cycles.
- RD_ADDR: mem_addr = pointer, mem_wen=0.
- RD_CAPTURE: register mem_rdata into {note, dur}.
  - dur=0: pulse done and go to IDLE.
  - Otherwise load the timer with dur*TICK_DIV and go to PLAY_NOTE.
- PLAY_NOTE: note_valid=1 and note_out=note (a rest plays as note 0 with valid high). On the last timer cycle, increment the pointer and go to RD_ADDR.
  - If the pointer wraps from 2^ADDR_W−1 to 0, pulse done and go to IDLE instead.
- stop=1 in RD_ADDR, RD_CAPTURE or PLAY_NOTE: go to IDLE next cycle with note_valid=0 and no done pulse.
- stop in write states is ignored, and it also clears play_pending.
- play while busy is ignored. wr_en while wr_ready=0 is dropped.
- Timer width is DUR_W + clog2(TICK_DIV+1); products never truncate.

## Timing
- Reset values:
  - state IDLE, so wr_ready=1.
  - busy=0, done=0, note_valid=0, note_out=0.
  - mem_wen=0, mem_addr=0, mem_wdata=0.
  - pointer=0, play_pending=0.
- Reset mid-write or mid-play aborts immediately. mem_wen is low on the cycle after rst is sampled.
- Write accepted at cycle t: mem_wen=1 only at t+2, and wr_ready returns at t+4.
- play at cycle t: note_valid first high at t+3.
- Each note holds note_valid for exactly dur*TICK_DIV cycles.
- There is a 2-cycle note_valid=0 gap between consecutive notes (RD_ADDR, RD_CAPTURE).
- done is asserted for one cycle: the RD_CAPTURE cycle on end-marker, or the final PLAY_NOTE cycle on wrap. The state is IDLE the following cycle.
- All outputs are registered except wr_ready and busy, which decode state.

## Structure
- Package music_seq_pkg contains:
  - the state enum;
  - NOTE_W and DUR_W defaults;
  - entry field slice positions;
  - END_DUR=0 and REST_NOTE=0.
- Sub-module note_timer is a loadable down-counter with load, value and last outputs, used for PLAY_NOTE.
- The song memory itself (latch array plus read mux) is external to this block.

## Test plan
- Reset then write {note=5, dur=2} to addr 3:
  - mem_wen high for exactly one cycle (t+2);
  - mem_addr=3 and mem_wdata=0x52 for t+1..t+3;
  - wr_ready back at t+4.
- Memory {0x31, 0x72, 0x00}, TICK_DIV=4, pulse play:
  - note 3 valid for 4 cycles, gap of 2, note 7 valid for 8 cycles, gap;
  - done pulse, then IDLE.
- All 32 entries with dur=1, play: 32 notes, done on the final note cycle, no re-read of addr 0.
- stop on the 2nd PLAY_NOTE cycle: next cycle note_valid=0, busy=0, done never asserted.
- wr_en and play in the same cycle: write completes (mem_wen at t+2), then playback starts from addr 0 with RD_ADDR at t+4.
- rst asserted during WR_PULSE: the following cycle has mem_wen=0, state IDLE, and all outputs at reset values.
